morse_tx_controller: RTL and testbench
======================================

Name: morse_tx_controller

Overview:
- Sequences one Morse letter (A–H) from a 3-bit letter select onto a single LED output.
- Looks up the letter's dot/dash pattern and its symbol count (1–4), then times the marks and spaces in units of TICKS_PER_UNIT clock cycles.
- Sits between the board switches/KEY debouncer and LEDR[0] in the Morse encoder lab top level.

Parameters:
- TICKS_PER_UNIT, 25000000: clock cycles per Morse time unit (0.5 s at 50 MHz); must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; returns block to IDLE.
- start  input  1  request to transmit; sampled only in IDLE.
- select  input  3  letter code: 000=A … 111=H.
- led  output  1  Morse output: 1 = mark (dot/dash), 0 = space.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse when a letter completes.

Behaviour:
- Reset values: led=0, busy=0, done=0; state=IDLE; shift register, symbol count and tick counter all 0.
- Encoding: pattern is 4 bits, sent MSB-first, 1 = dash, 0 = dot. Only the top `size` bits are used.
- Letter table (pattern / size):
  - A=01/2, B=1000/4, C=1010/4, D=100/3
  - E=0/1, F=0010/4, G=110/3, H=0000/4
- Durations: dot mark = 1 unit; dash mark = 3 units; inter-symbol space = 1 unit. The tick counter width covers 3*TICKS_PER_UNIT-1.
- State machine:
  - IDLE: if start=1 at edge N, latch select and go to LOAD (busy=1 from N+1).
  - LOAD (1 cycle): load the left-aligned pattern into the shift register, load size into the count, clear the tick counter, go to MARK.
  - MARK: led=1 for 1 or 3 units, chosen by the shift register MSB. At the end:
    - decrement count;
    - if count is now 0, go to DONE;
    - otherwise shift left by 1 and go to SPACE.
  - SPACE: led=0 for 1 unit, then go to MARK.
  - DONE (1 cycle): led=0, done=1, busy=1, then go to IDLE.
- Latency: with start high at edge N, led rises at N+2. The first cycle of MARK is the first cycle led=1.
- select changes while busy are ignored; the letter is latched at start.
- start while busy is ignored and not queued. start held high is level-sensitive: a new transmission begins on the cycle after returning to IDLE.
- reset mid-operation: next edge gives IDLE with led=0, busy=0, done=0, and no done pulse. Reset has priority over start.
- led, busy and done are registered outputs (no combinational path from inputs).

Optional Feature:
- Macro: MORSE_LETTER_GAP_EN.
- Defined: an extra state GAP is inserted between the last MARK and DONE. It holds led=0 for 3 units (the inter-letter gap), so back-to-back letters are correctly spaced.
- Undefined: the last MARK goes directly to DONE, as specified above.

Decomposition:
- Package morse_pkg holds:
  - state enum (IDLE, LOAD, MARK, SPACE, GAP, DONE);
  - DOT_UNITS=1, DASH_UNITS=3, SPACE_UNITS=1, GAP_UNITS=3;
  - pattern width 4, size width 3.
- Sub-module morse_letter_rom: purely combinational, select[2:0] -> pattern[3:0], size[2:0], implementing the letter table. The controller instantiates it and owns all sequencing.

Test Plan (TICKS_PER_UNIT=4):
- Reset, then idle with start=0 -> led=0, busy=0, done=0 for 20 cycles.
- select=000 (A), start pulse at edge N -> led high cycles N+2..N+5, low 4 cycles, high 12 cycles, then done=1 for exactly 1 cycle; busy falls the next cycle.
- select=100 (E) -> single 4-cycle mark, then done; total busy time 1+4+1 = 6 cycles.
- select=111 (H), toggle select to 110 and pulse start during transmission -> output is still four 4-cycle marks separated by 4-cycle spaces; no second transmission follows.
- Assert reset during the second mark of B (select=001) -> led=0 and busy=0 at the next edge, no done pulse; a following start transmits B correctly from the beginning.
- With MORSE_LETTER_GAP_EN and start held high, select=100 -> marks repeat with 4-cycle mark, 12-cycle gap, done, IDLE, LOAD, so the period is 4+12+3 = 19 cycles.

Source files
------------

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse letter transmitter.
//   state_e      : controller states (GAP is only reachable when the
//                  MORSE_LETTER_GAP_EN macro is defined)
//   *_UNITS      : mark/space durations in Morse time units
//   PATTERN_W    : width of the left-aligned dot/dash pattern (1 = dash)
//   SIZE_W       : width of the symbol count (1..4)
//   unit_end()   : last tick index of an interval lasting 'units' units
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MARK  = 3'd2,
        SPACE = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam int DOT_UNITS   = 1;
    localparam int DASH_UNITS  = 3;
    localparam int SPACE_UNITS = 1;
    localparam int GAP_UNITS   = 3;

    localparam int PATTERN_W = 4;
    localparam int SIZE_W    = 3;

    // The tick counter runs 0 .. units*tpu-1 inside one interval.
    function automatic int unit_end(input int units, input int tpu);
        return units * tpu - 1;
    endfunction

endpackage

// File: rtl/morse_letter_rom.sv
// -----------------------------------------------------------------------------
// morse_letter_rom
// Purely combinational letter table for A..H.
//   select_i  [2:0]  letter code, 000 = A ... 111 = H
//   pattern_o [3:0]  dot/dash pattern, left-aligned, MSB sent first, 1 = dash
//   size_o    [2:0]  number of symbols (1..4); only the top size_o bits of
//                    pattern_o are meaningful
// -----------------------------------------------------------------------------
module morse_letter_rom
    import morse_pkg::*;
(
    input  logic [2:0]           select_i,
    output logic [PATTERN_W-1:0] pattern_o,
    output logic [SIZE_W-1:0]    size_o
);

    always_comb begin
        pattern_o = '0;
        size_o    = SIZE_W'(1);
        case (select_i)
            3'd0: begin pattern_o = 4'b0100; size_o = 3'd2; end // A .-
            3'd1: begin pattern_o = 4'b1000; size_o = 3'd4; end // B -...
            3'd2: begin pattern_o = 4'b1010; size_o = 3'd4; end // C -.-.
            3'd3: begin pattern_o = 4'b1000; size_o = 3'd3; end // D -..
            3'd4: begin pattern_o = 4'b0000; size_o = 3'd1; end // E .
            3'd5: begin pattern_o = 4'b0010; size_o = 3'd4; end // F ..-.
            3'd6: begin pattern_o = 4'b1100; size_o = 3'd3; end // G --.
            3'd7: begin pattern_o = 4'b0000; size_o = 3'd4; end // H ....
            default: begin pattern_o = '0; size_o = SIZE_W'(1); end
        endcase
    end

endmodule

// File: rtl/morse_tx_controller.sv
// -----------------------------------------------------------------------------
// morse_tx_controller
// Transmits one Morse letter (A..H) on a single LED, timing marks and spaces
// in units of TICKS_PER_UNIT clock cycles.
//   clk     system clock, all state updates on the rising edge
//   reset   synchronous active-high reset, returns to IDLE
//   start   transmit request, sampled only in IDLE (level-sensitive)
//   select  letter code, latched when start is accepted
//   led     1 = mark, 0 = space (registered)
//   busy    high in every state except IDLE (registered)
//   done    one-cycle pulse when a letter completes (registered)
// Optional build macro MORSE_LETTER_GAP_EN: adds a 3-unit led=0 GAP state
// between the last mark and DONE so back-to-back letters are spaced.
// -----------------------------------------------------------------------------
module morse_tx_controller
    import morse_pkg::*;
#(
    parameter int TICKS_PER_UNIT = 25000000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] select,
    output logic       led,
    output logic       busy,
    output logic       done
);

    // Wide enough for the longest interval (a dash or gap: 3 units).
    localparam int TICK_W = $clog2(3 * TICKS_PER_UNIT);
    typedef logic [TICK_W-1:0] tick_t;

    localparam tick_t DOT_END   = tick_t'(unit_end(DOT_UNITS,   TICKS_PER_UNIT));
    localparam tick_t DASH_END  = tick_t'(unit_end(DASH_UNITS,  TICKS_PER_UNIT));
    localparam tick_t SPACE_END = tick_t'(unit_end(SPACE_UNITS, TICKS_PER_UNIT));
`ifdef MORSE_LETTER_GAP_EN
    localparam tick_t GAP_END   = tick_t'(unit_end(GAP_UNITS,   TICKS_PER_UNIT));
`endif

    state_e                 state_q, state_d;
    logic [2:0]             sel_q, sel_d;
    logic [PATTERN_W-1:0]   shift_q, shift_d;
    logic [SIZE_W-1:0]      count_q, count_d;
    tick_t                  tick_q, tick_d;
    logic                   led_q, led_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [PATTERN_W-1:0]   rom_pattern;
    logic [SIZE_W-1:0]      rom_size;
    tick_t                  mark_end;

    // The ROM looks at the latched letter, so select changes while busy
    // never reach the sequencer.
    morse_letter_rom u_rom (
        .select_i  (sel_q),
        .pattern_o (rom_pattern),
        .size_o    (rom_size)
    );

    assign mark_end = shift_q[PATTERN_W-1] ? DASH_END : DOT_END;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            shift_q <= '0;
            count_q <= '0;
            tick_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            shift_q <= shift_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        shift_d = shift_q;
        count_d = count_q;
        tick_d  = tick_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = select;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d = rom_pattern;
                count_d = rom_size;
                tick_d  = '0;
                state_d = MARK;
            end
            MARK: begin
                if (tick_q == mark_end) begin
                    tick_d  = '0;
                    count_d = count_q - SIZE_W'(1);
                    // count_q == 1 means this was the last symbol.
                    if (count_q == SIZE_W'(1)) begin
`ifdef MORSE_LETTER_GAP_EN
                        state_d = GAP;
`else
                        state_d = DONE;
`endif
                    end else begin
                        shift_d = {shift_q[PATTERN_W-2:0], 1'b0};
                        state_d = SPACE;
                    end
                end else begin
                    tick_d = tick_q + tick_t'(1);
                end
            end
            SPACE: begin
                if (tick_q == SPACE_END) begin
                    tick_d  = '0;
                    state_d = MARK;
                end else begin
                    tick_d = tick_q + tick_t'(1);
                end
            end
            GAP: begin
`ifdef MORSE_LETTER_GAP_EN
                if (tick_q == GAP_END) begin
                    tick_d  = '0;
                    state_d = DONE;
                end else begin
                    tick_d = tick_q + tick_t'(1);
                end
`else
                // Unreachable without the gap feature; recover to IDLE.
                tick_d  = '0;
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state register with no combinational path from the inputs.
        led_d  = (state_d == MARK);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_morse_tx_controller.sv
// -----------------------------------------------------------------------------
// tb_morse_tx_controller
// Stimulus pushes the expected per-cycle LED trace of each letter into a
// scoreboard queue; a monitor records what the DUT shows between busy rising
// and the done pulse and compares it against the head of the queue.
// Trace characters: '0' led low, '1' led high, 'D' done pulse, 'x' busy lost.
// -----------------------------------------------------------------------------
module tb_morse_tx_controller;

    localparam int T = 4;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic [2:0] select = 3'd0;
    logic       led;
    logic       busy;
    logic       done;

    morse_tx_controller #(.TICKS_PER_UNIT(T)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .select (select),
        .led    (led),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    int    cycle = 0;
    string exp_q[$];
    int    exp_sel_q[$];
    int    done_cyc[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Reference: Morse code strings turned into a per-cycle busy trace.
    function automatic string model(input int sel);
        string code;
        string s;
        int    n;
        case (sel)
            0: code = ".-";
            1: code = "-...";
            2: code = "-.-.";
            3: code = "-..";
            4: code = ".";
            5: code = "..-.";
            6: code = "--.";
            default: code = "....";
        endcase
        s = "0";                                  // LOAD cycle
        for (int i = 0; i < code.len(); i++) begin
            if (i > 0)
                for (int k = 0; k < T; k++) s = {s, "0"};
            n = (code[i] == "-") ? 3 * T : T;
            for (int k = 0; k < n; k++) s = {s, "1"};
        end
`ifdef MORSE_LETTER_GAP_EN
        for (int k = 0; k < 3 * T; k++) s = {s, "0"};
`endif
        s = {s, "D"};
        return s;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        bit    rec   = 1'b0;
        bit    after = 1'b0;
        string tr    = "";
        string c;
        string e;
        int    es;
        forever begin
            @(negedge clk);
            if (reset) begin
                rec   = 1'b0;
                after = 1'b0;
            end else if (after) begin
                after = 1'b0;
                check("busy_after_done", int'(busy), 0);
                check("done_width", int'(done), 0);
            end else begin
                if (!rec && busy) begin
                    rec = 1'b1;
                    tr  = "";
                end
                if (rec) begin
                    c  = !busy ? "x" : (done ? "D" : (led ? "1" : "0"));
                    tr = {tr, c};
                    if (c == "D" || c == "x" || tr.len() > 200) begin
                        rec = 1'b0;
                        after = (c == "D");
                        if (c == "D") done_cyc.push_back(cycle);
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL unexpected_tx: got %s, expected no transmission", tr);
                        end else begin
                            e  = exp_q.pop_front();
                            es = exp_sel_q.pop_front();
                            if (tr != e) begin
                                fails++;
                                $display("FAIL trace sel=%0d: got %s, expected %s", es, tr, e);
                            end else begin
                                $display("[TB] letter sel=%0d ok, %0d busy cycles", es, tr.len());
                            end
                        end
                    end
                end else begin
                    check("idle_led", int'(led), 0);
                    check("idle_done", int'(done), 0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int sel, input bit push);
        if (push) begin
            exp_q.push_back(model(sel));
            exp_sel_q.push_back(sel);
        end
        @(posedge clk);
        #1 select = 3'(sel);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        select = 3'($urandom_range(0, 7));
        @(negedge clk);
        check("busy_rise", int'(busy), 1);
    endtask

    // Random select/start activity while busy; start is dropped in DONE so
    // it is low when the controller samples it in IDLE.
    task automatic noise();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (done || !busy) begin
                start = 1'b0;
                return;
            end
            select = 3'($urandom_range(0, 7));
            start  = ($urandom_range(0, 2) == 0);
        end
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) return;
        end
        check("drain_timeout", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int  rises;
        bit  prev;
        int  sel;
        int  per;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        repeat (20) @(negedge clk);

        // A, then E
        send(0, 1'b1);
        drain();
        send(4, 1'b1);
        drain();

        // H with select toggled to G and a start pulse mid-transmission
        send(7, 1'b1);
        repeat (5) @(posedge clk);
        #1 select = 3'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain();
        repeat (10) @(negedge clk);

        // B aborted by reset during its second mark
        send(1, 1'b0);
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 200 && rises < 2; i++) begin
            @(negedge clk);
            if (led && !prev) rises++;
            prev = led;
        end
        check("second_mark_seen", rises, 2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_led", int'(led), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        repeat (8) @(negedge clk);
        send(1, 1'b1);
        drain();

        // Random letters, idle gaps and busy-time noise
        for (int n = 0; n < 16; n++) begin
            sel = $urandom_range(0, 7);
            send(sel, 1'b1);
            if ($urandom_range(0, 1) == 1) noise();
            drain();
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end

        // start held high: back-to-back E transmissions
        done_cyc.delete();
        for (int n = 0; n < 3; n++) begin
            exp_q.push_back(model(4));
            exp_sel_q.push_back(4);
        end
        @(posedge clk);
        #1 select = 3'd4;
        start = 1'b1;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        start = 1'b0;
        check("held_queue_empty", exp_q.size(), 0);
        drain();
        per = model(4).len() + 1;
        check("held_done_count", done_cyc.size(), 3);
        for (int i = 1; i < done_cyc.size(); i++)
            check("held_period", done_cyc[i] - done_cyc[i-1], per);

        repeat (10) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
